// File: rtl/tx_arb.sv
// tx_arb: two-requester AXI-Stream TX arbiter toward the MAC, with
// round-robin grant, per-packet lock and mid-packet stall timeout/abort.
// Params : TIMEOUT (stall cycles before abort), CNT_W (stall counter width)
// Ports  : clk156, eth_rst (async, active-high)
//          s0_axis_* / s1_axis_* : requester slaves (valid/ready/data/keep/last/user)
//          m_axis_*              : master toward MAC TX
//          grant (one-hot owner, 00 = none), abort_pulse (abort accepted)
// Macro  : TX_ARB_STRICT_PRIO_EN - ties in IDLE always go to port 0.
module tx_arb #(
  parameter int unsigned      CNT_W   = 16,
  parameter logic [CNT_W-1:0] TIMEOUT = 16'd1024
) (
  input  logic        clk156,
  input  logic        eth_rst,
  input  logic        s0_axis_tvalid,
  output logic        s0_axis_tready,
  input  logic [63:0] s0_axis_tdata,
  input  logic [7:0]  s0_axis_tkeep,
  input  logic        s0_axis_tlast,
  input  logic        s0_axis_tuser,
  input  logic        s1_axis_tvalid,
  output logic        s1_axis_tready,
  input  logic [63:0] s1_axis_tdata,
  input  logic [7:0]  s1_axis_tkeep,
  input  logic        s1_axis_tlast,
  input  logic        s1_axis_tuser,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic [1:0]  grant,
  output logic        abort_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_ABORT,
    ST_DRAIN
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_grant;
  logic [1:0]       w_grant_nxt;
  logic [CNT_W-1:0] r_stall;
  logic [CNT_W-1:0] w_stall_nxt;
`ifndef TX_ARB_STRICT_PRIO_EN
  logic             r_last;
  logic             w_last_nxt;
`endif

  logic        w_sel;
  logic        w_win1;
  logic        w_g_tvalid;
  logic [63:0] w_g_tdata;
  logic [7:0]  w_g_tkeep;
  logic        w_g_tlast;
  logic        w_g_tuser;

  // Granted slave mux; index by the upper one-hot bit.
  assign w_sel      = r_grant[1];
  assign w_g_tvalid = w_sel ? s1_axis_tvalid : s0_axis_tvalid;
  assign w_g_tdata  = w_sel ? s1_axis_tdata  : s0_axis_tdata;
  assign w_g_tkeep  = w_sel ? s1_axis_tkeep  : s0_axis_tkeep;
  assign w_g_tlast  = w_sel ? s1_axis_tlast  : s0_axis_tlast;
  assign w_g_tuser  = w_sel ? s1_axis_tuser  : s0_axis_tuser;

  // Port 1 wins alone, or on a tie when port 0 had the last grant.
`ifdef TX_ARB_STRICT_PRIO_EN
  assign w_win1 = s1_axis_tvalid & ~s0_axis_tvalid;
`else
  assign w_win1 = s1_axis_tvalid & (~s0_axis_tvalid | ~r_last);
`endif

  assign grant = r_grant;

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_stall_nxt    = r_stall;
`ifndef TX_ARB_STRICT_PRIO_EN
    w_last_nxt     = r_last;
`endif
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tkeep   = '0;
    m_axis_tlast   = 1'b0;
    m_axis_tuser   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    abort_pulse    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_stall_nxt = '0;
        if (s0_axis_tvalid | s1_axis_tvalid) begin
          w_grant_nxt = w_win1 ? 2'b10 : 2'b01;
`ifndef TX_ARB_STRICT_PRIO_EN
          w_last_nxt  = w_win1;
`endif
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        m_axis_tvalid  = w_g_tvalid;
        m_axis_tdata   = w_g_tdata;
        m_axis_tkeep   = w_g_tkeep;
        m_axis_tlast   = w_g_tlast;
        m_axis_tuser   = w_g_tuser;
        s0_axis_tready = ~w_sel & m_axis_tready;
        s1_axis_tready = w_sel & m_axis_tready;
        // Only a silent source counts; MAC backpressure never does.
        if (w_g_tvalid) begin
          w_stall_nxt = '0;
        end else if (r_stall != {CNT_W{1'b1}}) begin
          w_stall_nxt = r_stall + CNT_W'(1);
        end
        if (w_g_tvalid & m_axis_tready & w_g_tlast) begin
          w_grant_nxt = 2'b00;
          w_state_nxt = ST_IDLE;
        end else if (r_stall >= TIMEOUT) begin
          w_state_nxt = ST_ABORT;
        end
      end
      ST_ABORT: begin
        // Poisoned terminating beat so the MAC drops the frame.
        m_axis_tvalid = 1'b1;
        m_axis_tkeep  = 8'h01;
        m_axis_tlast  = 1'b1;
        m_axis_tuser  = 1'b1;
        if (m_axis_tready) begin
          abort_pulse = 1'b1;
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        s0_axis_tready = ~w_sel;
        s1_axis_tready = w_sel;
        if (w_g_tvalid & w_g_tlast) begin
          w_grant_nxt = 2'b00;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_grant_nxt = 2'b00;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk156 or posedge eth_rst) begin
    if (eth_rst) begin
      r_state <= ST_IDLE;
      r_grant <= 2'b00;
      r_stall <= '0;
`ifndef TX_ARB_STRICT_PRIO_EN
      r_last  <= 1'b1;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_stall <= w_stall_nxt;
`ifndef TX_ARB_STRICT_PRIO_EN
      r_last  <= w_last_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_tx_arb.sv
// tb_tx_arb: directed self-checking bench for tx_arb (TIMEOUT=8).
// Sources are small beat/packet counters; expectations are hand-derived.
module tb_tx_arb;

  logic        clk156 = 1'b0;
  logic        eth_rst = 1'b1;
  logic        s0_axis_tvalid, s0_axis_tready;
  logic [63:0] s0_axis_tdata;
  logic [7:0]  s0_axis_tkeep;
  logic        s0_axis_tlast, s0_axis_tuser;
  logic        s1_axis_tvalid, s1_axis_tready;
  logic [63:0] s1_axis_tdata;
  logic [7:0]  s1_axis_tkeep;
  logic        s1_axis_tlast, s1_axis_tuser;
  logic        m_axis_tvalid, m_axis_tready;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast, m_axis_tuser;
  logic [1:0]  grant;
  logic        abort_pulse;

  int checks = 0;
  int errors = 0;

  int  k0, k1, b0, b1, len0, len1;
  bit  v0, v1;

  always #5 clk156 = ~clk156;

  tx_arb #(.CNT_W(16), .TIMEOUT(16'd8)) dut (
    .clk156(clk156), .eth_rst(eth_rst),
    .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep),
    .s0_axis_tlast(s0_axis_tlast), .s0_axis_tuser(s0_axis_tuser),
    .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep),
    .s1_axis_tlast(s1_axis_tlast), .s1_axis_tuser(s1_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .grant(grant), .abort_pulse(abort_pulse)
  );

  function automatic logic [63:0] mk(input int p, input int k, input int b);
    return {8'hA5, 8'(p), 16'(k), 32'(b)};
  endfunction

  task automatic drive();
    s0_axis_tvalid = v0;
    s0_axis_tdata  = mk(0, k0, b0);
    s0_axis_tlast  = (b0 == len0 - 1);
    s0_axis_tkeep  = 8'hFF;
    s0_axis_tuser  = 1'b0;
    s1_axis_tvalid = v1;
    s1_axis_tdata  = mk(1, k1, b1);
    s1_axis_tlast  = (b1 == len1 - 1);
    s1_axis_tkeep  = (b1 == len1 - 1) ? 8'h0F : 8'hFF;
    s1_axis_tuser  = (b1 == 1);
  endtask

  // One clock: record handshakes, advance sources, settle outputs.
  task automatic step();
    bit a0, a1;
    a0 = s0_axis_tvalid & s0_axis_tready;
    a1 = s1_axis_tvalid & s1_axis_tready;
    @(posedge clk156);
    #1;
    if (a0) begin
      if (b0 == len0 - 1) begin b0 = 0; k0++; end else b0++;
    end
    if (a1) begin
      if (b1 == len1 - 1) begin b1 = 0; k1++; end else b1++;
    end
    drive();
    #1;
  endtask

  task automatic do_reset();
    eth_rst = 1'b1;
    v0 = 0; v1 = 0; k0 = 0; k1 = 0; b0 = 0; b1 = 0;
    len0 = 3; len1 = 3;
    m_axis_tready = 1'b0;
    drive();
    repeat (2) @(posedge clk156);
    #1;
    eth_rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    v0 = 1; v1 = 1; k0 = 0; k1 = 0; b0 = 0; b1 = 0;
    len0 = 3; len1 = 3;
    m_axis_tready = 1'b1;
    drive();
    @(posedge clk156);
    #2;
    checks++;
    if (grant !== 2'b00) begin
      errors++; $display("FAIL rst_grant got %b want 00", grant);
    end
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL rst_mvalid got %b want 0", m_axis_tvalid);
    end
    checks++;
    if ({s1_axis_tready, s0_axis_tready} !== 2'b00) begin
      errors++;
      $display("FAIL rst_sready got %b want 00",
               {s1_axis_tready, s0_axis_tready});
    end
    checks++;
    if (abort_pulse !== 1'b0) begin
      errors++; $display("FAIL rst_abort got %b want 0", abort_pulse);
    end
  endtask

  task automatic test_round_robin();
    int ph, p, k, bt;
    logic [1:0] eg;
    do_reset();
    m_axis_tready = 1'b1;
    v0 = 1; v1 = 1;
    drive();
    #1;
    for (int c = 0; c < 16; c++) begin
      ph = c % 4;
`ifdef TX_ARB_STRICT_PRIO_EN
      p = 0;
      k = c / 4;
`else
      p = (c / 4) % 2;
      k = c / 8;
`endif
      bt = ph - 1;
      eg = (ph == 0) ? 2'b00 : (p == 1 ? 2'b10 : 2'b01);
      checks++;
      if (grant !== eg || {s1_axis_tready, s0_axis_tready} !== eg) begin
        errors++;
        $display("FAIL rr_grant c=%0d got %b/%b want %b", c, grant,
                 {s1_axis_tready, s0_axis_tready}, eg);
      end
      checks++;
      if (m_axis_tvalid !== (ph != 0)) begin
        errors++;
        $display("FAIL rr_mvalid c=%0d got %b want %b", c,
                 m_axis_tvalid, (ph != 0));
      end
      if (ph != 0) begin
        checks++;
        if (m_axis_tdata !== mk(p, k, bt) || m_axis_tlast !== (bt == 2)
            || m_axis_tuser !== (p == 1 && bt == 1)
            || m_axis_tkeep !== ((p == 1 && bt == 2) ? 8'h0F : 8'hFF)) begin
          errors++;
          $display("FAIL rr_beat c=%0d got %h/%h/%b/%b want %h", c,
                   m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                   m_axis_tuser, mk(p, k, bt));
        end
      end
      step();
    end
  endtask

  task automatic test_abort();
    int n, pulses;
    do_reset();
    m_axis_tready = 1'b1;
    len0 = 5; v0 = 1;
    drive();
    #1;
    step();
    checks++;
    if (m_axis_tdata !== mk(0, 0, 0) || grant !== 2'b01) begin
      errors++;
      $display("FAIL ab_beat0 got %h/%b want %h/01", m_axis_tdata, grant,
               mk(0, 0, 0));
    end
    step();
    checks++;
    if (m_axis_tdata !== mk(0, 0, 1) || m_axis_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL ab_beat1 got %h want %h", m_axis_tdata, mk(0, 0, 1));
    end
    v0 = 0;
    step();
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (m_axis_tvalid !== 1'b0 || grant !== 2'b01 || abort_pulse !== 1'b0) begin
        errors++;
        $display("FAIL ab_stall%0d got v=%b g=%b p=%b want 0/01/0", i,
                 m_axis_tvalid, grant, abort_pulse);
      end
      step();
    end
    m_axis_tready = 1'b0;
    #1;
    n = 0;
    while (m_axis_tvalid !== 1'b1 && n < 4) begin
      step();
      n++;
    end
    checks++;
    if (m_axis_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL ab_timeout got no abort beat want one within 4 cycles");
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (m_axis_tdata !== 64'd0 || m_axis_tkeep !== 8'h01
          || m_axis_tlast !== 1'b1 || m_axis_tuser !== 1'b1
          || m_axis_tvalid !== 1'b1 || s0_axis_tready !== 1'b0
          || grant !== 2'b01 || abort_pulse !== 1'b0) begin
        errors++;
        $display("FAIL ab_beat%0d got %h/%h/%b/%b/%b r=%b g=%b p=%b", i,
                 m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser,
                 m_axis_tvalid, s0_axis_tready, grant, abort_pulse);
      end
      if (i == 0) step();
    end
    pulses = 0;
    m_axis_tready = 1'b1;
    v0 = 1;
    drive();
    #1;
    pulses += int'(abort_pulse);
    step();
    for (int i = 0; i < 3; i++) begin
      pulses += int'(abort_pulse);
      checks++;
      if (m_axis_tvalid !== 1'b0 || s0_axis_tready !== 1'b1
          || grant !== 2'b01) begin
        errors++;
        $display("FAIL ab_drain%0d got v=%b r=%b g=%b want 0/1/01", i,
                 m_axis_tvalid, s0_axis_tready, grant);
      end
      step();
    end
    checks++;
    if (grant !== 2'b00 || k0 != 1) begin
      errors++;
      $display("FAIL ab_idle got g=%b pkt=%0d want 00/1", grant, k0);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL ab_pulse got %0d pulses want 1", pulses);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    do_reset();
    m_axis_tready = 1'b1;
    len0 = 5; v0 = 1;
    drive();
    #1;
    step();
    step();
    m_axis_tready = 1'b0;
    #1;
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== mk(0, 0, 1)
          || m_axis_tkeep !== 8'hFF || grant !== 2'b01
          || abort_pulse !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold got %0d bad cycles want 0", bad);
    end
    m_axis_tready = 1'b1;
    #1;
    for (int b = 1; b < 5; b++) begin
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== mk(0, 0, b)
          || m_axis_tlast !== (b == 4)) begin
        errors++;
        $display("FAIL bp_beat%0d got %h/%b want %h", b, m_axis_tdata,
                 m_axis_tlast, mk(0, 0, b));
      end
      step();
    end
    checks++;
    if (grant !== 2'b00) begin
      errors++; $display("FAIL bp_idle got %b want 00", grant);
    end
  endtask

  task automatic test_lock();
    do_reset();
    m_axis_tready = 1'b1;
    len0 = 4; v0 = 1;
    drive();
    #1;
    step();
    v1 = 1;
    drive();
    #1;
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (s1_axis_tready !== 1'b0 || grant !== 2'b01
          || m_axis_tdata !== mk(0, 0, b)) begin
        errors++;
        $display("FAIL lk_beat%0d got r1=%b g=%b d=%h want 0/01/%h", b,
                 s1_axis_tready, grant, m_axis_tdata, mk(0, 0, b));
      end
      step();
    end
    checks++;
    if (grant !== 2'b00 || s1_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL lk_idle got g=%b r1=%b want 00/0", grant, s1_axis_tready);
    end
    step();
    checks++;
    if (grant !== 2'b10 || s1_axis_tready !== 1'b1
        || m_axis_tdata !== mk(1, 0, 0) || m_axis_tuser !== 1'b0) begin
      errors++;
      $display("FAIL lk_p1 got g=%b r1=%b d=%h u=%b want 10/1/%h/0", grant,
               s1_axis_tready, m_axis_tdata, m_axis_tuser, mk(1, 0, 0));
    end
    step();
    checks++;
    if (m_axis_tdata !== mk(1, 0, 1) || m_axis_tuser !== 1'b1) begin
      errors++;
      $display("FAIL lk_tuser got %h/%b want %h/1", m_axis_tdata,
               m_axis_tuser, mk(1, 0, 1));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_axis_tready = 1'b1;
    v0 = 1; v1 = 1;
    drive();
    #1;
    step();
    checks++;
    if (grant !== 2'b01 || m_axis_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL rm_send got g=%b v=%b want 01/1", grant, m_axis_tvalid);
    end
    #2;
    eth_rst = 1'b1;
    #1;
    checks++;
    if (grant !== 2'b00 || m_axis_tvalid !== 1'b0
        || {s1_axis_tready, s0_axis_tready} !== 2'b00) begin
      errors++;
      $display("FAIL rm_async got g=%b v=%b r=%b want 00/0/00", grant,
               m_axis_tvalid, {s1_axis_tready, s0_axis_tready});
    end
    @(posedge clk156);
    #1;
    eth_rst = 1'b0;
    b0 = 0; b1 = 0;
    drive();
    #1;
    checks++;
    if (grant !== 2'b00) begin
      errors++; $display("FAIL rm_idle got %b want 00", grant);
    end
    step();
    checks++;
    if (grant !== 2'b01 || m_axis_tdata !== mk(0, 0, 0)) begin
      errors++;
      $display("FAIL rm_tie got g=%b d=%h want 01/%h", grant, m_axis_tdata,
               mk(0, 0, 0));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_abort();
    test_backpressure();
    test_lock();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_arb.md
TX_ARB -- requirements
Module: tx_arb

Interface
REQ-001 Parameter TIMEOUT, default 16'd1024, stall cycles tolerated mid-packet on the granted port before abort.
REQ-002 Parameter CNT_W, default 16, width of the stall counter; TIMEOUT SHALL fit in CNT_W bits.
REQ-003 Port clk156  in  1  sole clock, 156.25 MHz MAC core clock.
REQ-004 Port eth_rst  in  1  asynchronous, active-high reset.
REQ-005 Ports s0_axis_tvalid/tready/tdata/tkeep/tlast/tuser  in/out/in/in/in/in  1/1/64/8/1/1  requester 0 AXI-Stream slave.
REQ-006 Ports s1_axis_tvalid/tready/tdata/tkeep/tlast/tuser  in/out/in/in/in/in  1/1/64/8/1/1  requester 1 AXI-Stream slave.
REQ-007 Ports m_axis_tvalid/tready/tdata/tkeep/tlast/tuser  out/in/out/out/out/out  1/1/64/8/1/1  master toward MAC TX.
REQ-008 Port grant  out  2  one-hot current owner: 01 = port 0, 10 = port 1, 00 = none.
REQ-009 Port abort_pulse  out  1  one-cycle pulse when a packet is aborted by timeout.

Function
REQ-010 States: IDLE, SEND, ABORT, DRAIN; the state register SHALL be the only arbitration state besides last_grant and the stall counter.
REQ-011 IDLE: when any s*_axis_tvalid=1, the winner SHALL be registered into grant and the FSM SHALL enter SEND on the next edge; all s*_tready=0 and m_axis_tvalid=0 in IDLE.
REQ-012 Round-robin: if only one port is valid it wins; if both are valid, the port not equal to last_grant wins; last_grant updates on every grant.
REQ-013 SEND: m_axis_* SHALL be a combinational pass-through of the granted slave (zero latency); the granted s_tready SHALL equal m_axis_tready; the other s_tready SHALL be 0.
REQ-014 SEND exits to IDLE on the edge where the granted beat with tlast=1 is accepted (tvalid&tready); one bubble cycle between packets is required.
REQ-015 Grant SHALL NOT change mid-packet, whatever the other port does.
REQ-016 Stall counter: cleared on entry to SEND and on every cycle with granted tvalid=1; increments on each SEND cycle with granted tvalid=0; saturates, never wraps.
REQ-017 When the stall counter reaches TIMEOUT, the FSM SHALL enter ABORT on the next edge.
REQ-018 ABORT: m_axis_tvalid=1, tdata=0, tkeep=8'h01, tlast=1, tuser=1 (MAC discards frame); all s_tready=0; held until m_axis_tready=1, then DRAIN; abort_pulse=1 on the ABORT->DRAIN edge cycle.
REQ-019 DRAIN: granted s_tready=1, beats discarded, m_axis_tvalid=0; exit to IDLE after the accepted beat with tlast=1.
REQ-020 A stall beginning after m_axis_tready drops (backpressure) SHALL NOT count; only granted tvalid=0 counts.
REQ-021 grant SHALL read 00 in IDLE and hold the owner in SEND, ABORT and DRAIN.
REQ-022 Source tuser SHALL pass through unmodified in SEND.

Reset
REQ-023 eth_rst=1 SHALL asynchronously force IDLE, grant=00, last_grant=port 1 (port 0 wins first tie), stall counter=0, abort_pulse=0, m_axis_tvalid=0, all s_tready=0.
REQ-024 Reset mid-packet SHALL drop the packet without emitting tlast; recovery of the MAC side is the MAC's responsibility.
REQ-025 Outputs SHALL reach reset values within the same cycle eth_rst asserts; release is synchronous to clk156 by the driver of eth_rst.

Configuration
REQ-026 Macro TX_ARB_STRICT_PRIO_EN: when defined, ties in IDLE SHALL always grant port 0 and last_grant is unused; when undefined, round-robin per REQ-012 applies.
REQ-027 The macro SHALL NOT alter ports, timeout or abort behaviour.

Verification
REQ-028 Both ports present 3-beat packets continuously, m_tready=1 -> m_axis carries packets alternating 0,1,0,1, grant 01/10 alternating, one idle cycle between packets.
REQ-029 Same stimulus with TX_ARB_STRICT_PRIO_EN -> only port-0 packets forwarded while port 0 stays valid; port 1 starved.
REQ-030 Port 0 sends 2 beats then drops tvalid for TIMEOUT=8 cycles -> ABORT beat tkeep=8'h01, tlast=1, tuser=1; abort_pulse one cycle; remaining port-0 beats drained with m_tvalid=0.
REQ-031 m_tready held 0 for 2000 cycles mid-packet with TIMEOUT=8 -> no abort; packet completes intact after m_tready=1.
REQ-032 Port 1 requests while port 0 mid-packet -> port 1 s_tready=0 until port 0 tlast accepted, then grant=10 after one IDLE cycle.
REQ-033 eth_rst pulsed during SEND -> grant=00, m_tvalid=0 immediately; next tie after release granted to port 0.
